// File: rtl/width_pack_fifo.sv
// Narrow-to-wide packing FIFO: RATIO narrow words form one wide first-word-fall-through entry.
// Define PACK_FLUSH_PAD_EN to store flushed partial words zero-padded instead of discarding them.
module width_pack_fifo #(
  parameter int IN_WIDTH         = 72,
  parameter int RATIO            = 4,
  parameter int DEPTH            = 16,
  parameter int PROG_FULL_THRESH = DEPTH - 2,
  localparam int OUT_W  = IN_WIDTH * RATIO,
  localparam int LANE_W = $clog2(RATIO + 1),
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [IN_WIDTH-1:0] din,
  input  logic              wr_en,
  input  logic              wr_flush,
  output logic              full,
  output logic              prog_full,
  input  logic              rd_en,
  output logic [OUT_W-1:0]  dout,
  output logic [LANE_W-1:0] dout_lanes,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int SH_W = IN_WIDTH * (RATIO - 1);
  localparam int LC_W = $clog2(RATIO);

  // Handshake: a narrow word is taken on any edge where wr_en && !full, and the head
  // entry is popped on any edge where rd_en && !empty; neither strobe has to be held.

  logic [LC_W-1:0]  lane_q, lane_d, lane_n;
  logic [SH_W-1:0]  sh_q, sh_d, sh_n;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             flush_pend_q, flush_pend_d;
  logic             wr_acc, rd_do, wr_do;
  logic [OUT_W-1:0] packed_word, wr_word;
  logic [OUT_W-1:0] mem_data [DEPTH];
`ifdef PACK_FLUSH_PAD_EN
  logic [LANE_W-1:0] mem_lanes [DEPTH];
  logic [LANE_W-1:0] wr_lanes;
  logic [OUT_W-1:0]  pad_word;
  logic              room;
`endif

  always_comb begin
    full = ((count_q == CNT_W'(DEPTH)) && (lane_q == LC_W'(RATIO - 1))) || flush_pend_q;
    wr_acc = wr_en && !full;
    rd_do  = rd_en && !empty_q;
    // The newest narrow word always lands in the lowest lane, so the first word ends up on top.
    packed_word = {sh_q, din};
    lane_n = lane_q;
    sh_n   = sh_q;
    wr_do  = 1'b0;
    if (wr_acc) begin
      sh_n = packed_word[SH_W-1:0];
      if (lane_q == LC_W'(RATIO - 1)) begin
        lane_n = '0;
        wr_do  = 1'b1;
      end else begin
        lane_n = lane_q + LC_W'(1);
      end
    end
    wr_word      = packed_word;
    lane_d       = lane_n;
    sh_d         = sh_n;
    flush_pend_d = flush_pend_q;
`ifdef PACK_FLUSH_PAD_EN
    wr_lanes = LANE_W'(RATIO);
    room     = (count_q != CNT_W'(DEPTH)) || rd_do;
    pad_word = {sh_n, {IN_WIDTH{1'b0}}} << (IN_WIDTH * (RATIO - 1 - int'(lane_n)));
    if (flush_pend_q) begin
      // A parked flush waits for a slot that is free before the edge.
      if (count_q != CNT_W'(DEPTH)) begin
        wr_do        = 1'b1;
        wr_word      = pad_word;
        wr_lanes     = LANE_W'(lane_n);
        lane_d       = '0;
        flush_pend_d = 1'b0;
      end
    end else if (wr_flush && (lane_n != '0)) begin
      if (room) begin
        wr_do    = 1'b1;
        wr_word  = pad_word;
        wr_lanes = LANE_W'(lane_n);
        lane_d   = '0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end
`else
    if (wr_flush) lane_d = '0;
    flush_pend_d = 1'b0;
`endif
    wptr_d  = wptr_q + PTR_W'(wr_do);
    rptr_d  = rptr_q + PTR_W'(rd_do);
    count_d = count_q + CNT_W'(wr_do) - CNT_W'(rd_do);
    // An entry written on this edge stays hidden until the following edge.
    empty_d = (count_d == CNT_W'(wr_do));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lane_q       <= '0;
      sh_q         <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      flush_pend_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      sh_q         <= sh_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem_data[wptr_q] <= wr_word;
`ifdef PACK_FLUSH_PAD_EN
      mem_lanes[wptr_q] <= wr_lanes;
`endif
    end
  end

  always_comb begin
    empty     = empty_q;
    count     = count_q;
    prog_full = (count_q >= CNT_W'(PROG_FULL_THRESH));
    dout      = empty_q ? '0 : mem_data[rptr_q];
`ifdef PACK_FLUSH_PAD_EN
    dout_lanes = empty_q ? '0 : mem_lanes[rptr_q];
`else
    dout_lanes = empty_q ? '0 : LANE_W'(RATIO);
`endif
  end

endmodule

// File: doc/width_pack_fifo.md
WIDTH_PACK_FIFO -- requirements
Module: width_pack_fifo

Interface
REQ-001 Parameter IN_WIDTH, default 72, width of one narrow input word.
REQ-002 Parameter RATIO, default 4, narrow words per wide output word; legal range 2..8.
REQ-003 Parameter DEPTH, default 16, wide-word storage entries; power of two, >= 4.
REQ-004 Parameter PROG_FULL_THRESH, default DEPTH-2, stored-entry count at or above which prog_full asserts.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 arst  input  1  reset; asynchronous assert, active-high.
REQ-007 din  input  IN_WIDTH  narrow write data, sampled in the same cycle as wr_en.
REQ-008 wr_en  input  1  write strobe; accepted only when full is low.
REQ-009 wr_flush  input  1  close the current partial wide word.
REQ-010 full  output  1  write side cannot accept wr_en.
REQ-011 prog_full  output  1  stored entries >= PROG_FULL_THRESH.
REQ-012 rd_en  input  1  pop head entry; ignored when empty is high.
REQ-013 dout  output  IN_WIDTH*RATIO  head wide word, first-word-fall-through.
REQ-014 dout_lanes  output  clog2(RATIO+1)  valid narrow lanes in dout; RATIO for a complete word.
REQ-015 empty  output  1  no stored entry.
REQ-016 count  output  clog2(DEPTH+1)  stored wide entries.

Function
REQ-017 Packer holds lane_cnt (0..RATIO-1) and a shift register of RATIO-1 lanes.
REQ-018 The first accepted word of a wide word occupies the most-significant lane; later words go to successively lower lanes.
REQ-019 The RATIO-th accepted word completes the wide word, which is written to storage in the same clock edge with dout_lanes = RATIO; lane_cnt returns to 0.
REQ-020 full = (count == DEPTH) AND (lane_cnt == RATIO-1), or flush_pend high.
REQ-021 Storage latency: an entry written at edge N is visible on dout with empty low after edge N+1.
REQ-022 dout and dout_lanes hold the head entry while empty is low; rd_en pops on the edge; contents are don't-care while empty is high.
REQ-023 A read and a write on the same edge are both performed, including when count == DEPTH; count is unchanged.
REQ-024 Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 wr_en with full high is dropped; packer and storage are unchanged.
REQ-026 When wr_flush is high with lane_cnt == 0 and wr_en low, there is no effect.
REQ-027 When wr_en and wr_flush are high in the same cycle, din is packed first, then the flush applies to the result.
REQ-028 The flush action depends on PACK_FLUSH_PAD_EN (REQ-033/034).
REQ-029 A padded flush with count == DEPTH and no same-cycle read sets flush_pend.
REQ-030 While flush_pend is high, wr_en is dropped; the padded word writes on the first edge with space; flush_pend then clears.

Reset
REQ-031 arst high immediately clears pointers, count, lane_cnt and flush_pend.
REQ-032 During arst: empty = 1, full = 0, prog_full = 0, count = 0, dout = 0, dout_lanes = 0; a partial word is discarded.

Configuration
REQ-033 With PACK_FLUSH_PAD_EN defined, a flush with lane_cnt > 0 writes the partial word with unfilled low lanes zero, dout_lanes = lane_cnt, and lane_cnt cleared to 0.
REQ-034 Without PACK_FLUSH_PAD_EN, a flush discards the residue and clears lane_cnt to 0; flush_pend does not exist (constant 0); dout_lanes is always RATIO.

Verification
REQ-035 Defaults; 8 writes A0..A7, then read 2 -> dout {A0,A1,A2,A3} lanes=4, then {A4,A5,A6,A7}; empty = 1 after the second pop.
REQ-036 Write 16*4+3 words with no reads -> count = 16, full = 1 after the 67th write; a 68th wr_en is dropped; one rd_en then frees space.
REQ-037 PAD_EN: write B0,B1 then flush -> dout {B0,B1,0,0} lanes=2; without PAD_EN -> empty remains 1, and next 4 writes produce an aligned word.
REQ-038 PAD_EN, count = 16, lane_cnt = 1, flush -> flush_pend, full = 1; rd_en -> padded word enters the next edge; full clears.
REQ-039 Steady simultaneous rd_en/write at count = 8 for 100 cycles -> count constant, data in order across pointer wrap.
REQ-040 Assert arst mid-word (lane_cnt = 2, count = 5) -> all outputs reach their reset values without a clock edge; first post-reset word is lane-aligned.
